dmem_lane_arbiter: RTL and testbench

Arbitrates the two pipeline lanes' memory-stage requests onto the dual-port dmem of the 2-wide processor. Lane0 is the older instruction in program order and lane1 the younger. Requests with no conflict go to ports a and b in the same cycle. A same-address hazard (at least one store) is split over two cycles, with a stall back to the pipeline. The block sits between the X/M pipeline register and the dmem instance and also keeps a performance counter of split events.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_lane_arbiter_detect.sv | 30 +++
 rtl/dmem_lane_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_lane_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the dual-lane dmem arbiter: default widths, FSM states, request record.
// The request record is sized by the package widths; the arbiter's parameters default to them.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_arbiter_detect.sv
// Combinational same-address hazard detect between lane0 and lane1 (zero latency, no flow control).
// DMEM_STORE_MERGE_EN: a store-store pair is flagged for merging instead of splitting.
module dmem_conflict_detect
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              lane0_valid,
  input  logic              lane0_we,
  input  logic [ADDR_W-1:0] lane0_addr,
  input  logic              lane1_valid,
  input  logic              lane1_we,
  input  logic [ADDR_W-1:0] lane1_addr,
  output logic              conflict,
  output logic              store_merge
);

  logic same_addr;

  assign same_addr = lane0_valid & lane1_valid & (lane0_addr == lane1_addr);
  // Two loads to one word are harmless on a dual-port RAM.
  assign conflict  = same_addr & (lane0_we | lane1_we);

`ifdef DMEM_STORE_MERGE_EN
  assign store_merge = same_addr & lane0_we & lane1_we;
`else
  assign store_merge = 1'b0;
`endif

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Maps two lane memory ops onto dmem ports a/b; same-address hazards take a second cycle with stall_out.
// Zero-latency combinational port drive; one stall cycle per split. Optional macro DMEM_STORE_MERGE_EN.
module dmem_lane_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lane0_valid,
  input  logic              lane0_we,
  input  logic [ADDR_W-1:0] lane0_addr,
  input  logic [DATA_W-1:0] lane0_wdata,
  input  logic              lane1_valid,
  input  logic              lane1_we,
  input  logic [ADDR_W-1:0] lane1_addr,
  input  logic [DATA_W-1:0] lane1_wdata,
  input  logic              flush,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_a,
  output logic              wren_b,
  output logic [DATA_W-1:0] lane0_rdata,
  output logic [DATA_W-1:0] lane1_rdata,
  output logic              stall_out,
  output logic [CNT_W-1:0]  conflict_count
);

  state_t           state_q;
  req_t             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             conflict;
  logic             store_merge;
  logic             split;

  dmem_conflict_detect #(.ADDR_W(ADDR_W)) u_detect (
    .lane0_valid (lane0_valid),
    .lane0_we    (lane0_we),
    .lane0_addr  (lane0_addr),
    .lane1_valid (lane1_valid),
    .lane1_we    (lane1_we),
    .lane1_addr  (lane1_addr),
    .conflict    (conflict),
    .store_merge (store_merge)
  );

  assign split = conflict & ~store_merge;

  always_comb begin
    address_a = '0;
    data_a    = '0;
    wren_a    = 1'b0;
    address_b = '0;
    data_b    = '0;
    wren_b    = 1'b0;
    stall_out = 1'b0;
    if (!reset) begin
      address_a = lane0_addr;
      data_a    = lane0_wdata;
      if (state_q == RUN) begin
        // A merged store pair lets lane1's (younger) value win on port b alone.
        wren_a    = lane0_valid & lane0_we & ~store_merge;
        address_b = lane1_addr;
        data_b    = lane1_wdata;
        wren_b    = lane1_valid & lane1_we & ~split;
        stall_out = split;
      end else begin
        address_b = pend_q.addr;
        data_b    = pend_q.wdata;
        wren_b    = pend_q.valid & pend_q.we & ~flush;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      if (split) begin
        state_q <= SPLIT;
        pend_q  <= '{valid: 1'b1, we: lane1_we, addr: lane1_addr, wdata: lane1_wdata};
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      // The deferred lane1 op is issued (or flushed) this cycle either way.
      state_q <= RUN;
      pend_q  <= '0;
    end
  end

  assign lane0_rdata    = q_a;
  assign lane1_rdata    = q_b;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter with a behavioural dual-port dmem clocked on the falling edge.
module tb_dmem_lane_arbiter;
  import dmem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        lane0_valid, lane0_we, lane1_valid, lane1_we, flush;
  logic [11:0] lane0_addr, lane1_addr, address_a, address_b;
  logic [31:0] lane0_wdata, lane1_wdata, q_a, q_b, data_a, data_b;
  logic [31:0] lane0_rdata, lane1_rdata, conflict_count;
  logic        wren_a, wren_b, stall_out;

  logic [31:0] mem [0:4095];
  logic [34:0] exp_q [$];
  logic [31:0] rd_q [$];
  logic [34:0] e;
  logic [31:0] r;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] base_cnt;

  always #5 clock = ~clock;

  dmem_lane_arbiter dut (
    .clock(clock), .reset(reset),
    .lane0_valid(lane0_valid), .lane0_we(lane0_we), .lane0_addr(lane0_addr), .lane0_wdata(lane0_wdata),
    .lane1_valid(lane1_valid), .lane1_we(lane1_we), .lane1_addr(lane1_addr), .lane1_wdata(lane1_wdata),
    .flush(flush), .q_a(q_a), .q_b(q_b),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .wren_a(wren_a), .wren_b(wren_b), .lane0_rdata(lane0_rdata), .lane1_rdata(lane1_rdata),
    .stall_out(stall_out), .conflict_count(conflict_count)
  );

  // dmem: read-old-data, both ports, on ~clock
  always @(negedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end

  function automatic logic [34:0] obs();
    return {wren_a, wren_b, stall_out, conflict_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #2;
  endtask

  task automatic set_lanes(input logic v0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                           input logic v1, input logic w1, input logic [11:0] a1, input logic [31:0] d1);
    lane0_valid = v0; lane0_we = w0; lane0_addr = a0; lane0_wdata = d0;
    lane1_valid = v1; lane1_we = w1; lane1_addr = a1; lane1_wdata = d1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    set_lanes(1, 1, 12'h010, 32'h55, 1, 1, 12'h010, 32'h66);
    exp_q.push_back({3'b000, 32'd0});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
    checks++;
    if (address_a !== 12'h0 || data_a !== 32'h0) begin
      errors++; $display("FAIL reset_addr_a: got %h/%h want 0/0", address_a, data_a);
    end
    tick();
    reset = 1'b0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({3'b000, 32'd0});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e || dut.state_q !== RUN) begin
      errors++; $display("FAIL reset_state: got %h/%0d want %h/RUN", obs(), dut.state_q, e);
    end
  endtask

  task automatic test_no_conflict();
    tick();
    set_lanes(1, 1, 12'h010, 32'hAAAA0001, 1, 0, 12'h020, 32'h0);
    exp_q.push_back({3'b100, 32'd0});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL no_conflict: got %h want %h", obs(), e); end
    checks++;
    if (mem[12'h010] !== 32'hAAAA0001) begin
      errors++; $display("FAIL no_conflict_mem: got %h want aaaa0001", mem[12'h010]);
    end
  endtask

  task automatic test_split();
    tick();
    set_lanes(1, 1, 12'h040, 32'h12345678, 1, 0, 12'h040, 32'h0);
    exp_q.push_back({3'b101, 32'd0});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL split_c1: got %h want %h", obs(), e); end
    tick();
    // live lane1 inputs changed: port b must come from the pending copy
    set_lanes(1, 1, 12'h040, 32'h12345678, 1, 1, 12'h123, 32'hBAD0BAD0);
    exp_q.push_back({3'b000, 32'd1});
    rd_q.push_back(32'h12345678);
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL split_c2: got %h want %h", obs(), e); end
    checks++;
    if (address_b !== 12'h040) begin errors++; $display("FAIL split_addr_b: got %h want 040", address_b); end
    r = rd_q.pop_front(); checks++;
    if (lane1_rdata !== r) begin errors++; $display("FAIL split_rdata: got %h want %h", lane1_rdata, r); end
    tick();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({3'b000, 32'd1});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL split_after: got %h want %h", obs(), e); end
  endtask

  task automatic test_load_load();
    tick();
    set_lanes(1, 0, 12'h040, 32'h0, 1, 0, 12'h040, 32'h0);
    exp_q.push_back({3'b000, 32'd1});
    rd_q.push_back(32'h12345678);
    rd_q.push_back(32'h12345678);
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL load_load: got %h want %h", obs(), e); end
    r = rd_q.pop_front(); checks++;
    if (lane0_rdata !== r) begin errors++; $display("FAIL load_load_r0: got %h want %h", lane0_rdata, r); end
    r = rd_q.pop_front(); checks++;
    if (lane1_rdata !== r) begin errors++; $display("FAIL load_load_r1: got %h want %h", lane1_rdata, r); end
  endtask

  task automatic test_flush();
    tick();
    set_lanes(1, 0, 12'h040, 32'h0, 1, 1, 12'h040, 32'hDEAD);
    exp_q.push_back({3'b001, 32'd1});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL flush_c1: got %h want %h", obs(), e); end
    tick();
    flush = 1'b1;
    exp_q.push_back({3'b000, 32'd2});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL flush_c2: got %h want %h", obs(), e); end
    tick();
    flush = 1'b0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (mem[12'h040] !== 32'h12345678) begin
      errors++; $display("FAIL flush_mem: got %h want 12345678", mem[12'h040]);
    end
  endtask

  task automatic test_store_store();
    tick();
    set_lanes(1, 1, 12'h008, 32'h1, 1, 1, 12'h008, 32'h2);
`ifdef DMEM_STORE_MERGE_EN
    exp_q.push_back({3'b010, 32'd2});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL merge_c1: got %h want %h", obs(), e); end
    base_cnt = 32'd2;
`else
    exp_q.push_back({3'b101, 32'd2});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL ss_split_c1: got %h want %h", obs(), e); end
    tick();
    exp_q.push_back({3'b010, 32'd3});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL ss_split_c2: got %h want %h", obs(), e); end
    base_cnt = 32'd3;
`endif
    tick();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (mem[12'h008] !== 32'h2 || conflict_count !== base_cnt) begin
      errors++; $display("FAIL store_store_final: got %h/%0d want 2/%0d", mem[12'h008], conflict_count, base_cnt);
    end
  endtask

  task automatic test_reset_in_split();
    tick();
    set_lanes(1, 1, 12'h050, 32'h5, 0, 0, 0, 0);
    tick();
    set_lanes(1, 0, 12'h050, 32'h0, 1, 1, 12'h050, 32'h77);
    exp_q.push_back({3'b001, base_cnt});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL rst_split_c1: got %h want %h", obs(), e); end
    tick();
    reset = 1'b1;
    exp_q.push_back({3'b000, base_cnt + 32'd1});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL rst_split_c2: got %h want %h", obs(), e); end
    tick();
    reset = 1'b0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({3'b000, 32'd0});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e || dut.state_q !== RUN) begin
      errors++; $display("FAIL rst_split_after: got %h/%0d want %h/RUN", obs(), dut.state_q, e);
    end
    checks++;
    if (mem[12'h050] !== 32'h5) begin errors++; $display("FAIL rst_split_mem: got %h want 5", mem[12'h050]); end
  endtask

  task automatic test_saturate();
    tick();
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    set_lanes(1, 1, 12'h060, 32'h9, 1, 0, 12'h060, 32'h0);
    exp_q.push_back({3'b101, 32'hFFFFFFFF});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL sat_c1: got %h want %h", obs(), e); end
    tick();
    exp_q.push_back({3'b000, 32'hFFFFFFFF});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL sat_c2: got %h want %h", obs(), e); end
    tick();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back({3'b000, 32'hFFFFFFFF});
    sample();
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL sat_after: got %h want %h", obs(), e); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    base_cnt = 32'd0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_no_conflict();
    test_split();
    test_load_load();
    test_flush();
    test_store_store();
    test_reset_in_split();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
